// File: rtl/bram_sd_seq.sv
// bram_sd_seq: sequences backup-RAM load/save between the core and the SD image, plus format writes.
// Optional autosave after AUTOSAVE_CYC idle cycles following a core write: define BRAM_AUTOSAVE_EN.
module bram_sd_seq #(
    parameter int          SEC_BITS     = 4,
    parameter int          SLOT_BITS    = 2,
    parameter int          FMT_WORDS    = 4,
    parameter logic [23:0] AUTOSAVE_CYC = 24'd10_000_000,
    localparam int         FMT_IDX_W    = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 bk_ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 format_req,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 core_wr,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic                 bram_b_sd,
    output logic [FMT_IDX_W-1:0] fmt_idx,
    output logic                 fmt_we,
    output logic                 busy,
    output logic                 loading,
    output logic                 err,
    output logic                 dirty,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_FMT  = 2'd2
    } state_t;

    state_t               state;
    logic                 load_q, load_qq;
    logic                 save_q, save_qq;
    logic                 fmt_q, fmt_qq;
    logic                 ack_q, ack_qq;
    logic [SLOT_BITS-1:0] slot_r;
    logic [SEC_BITS-1:0]  sec;

    // Edges come from the second register stage so a request takes two cycles to reach sd_rd/sd_wr.
    logic load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
    assign load_edge = load_q & ~load_qq;
    assign save_edge = save_q & ~save_qq;
    assign fmt_edge  = fmt_q & ~fmt_qq;
    assign ack_rise  = ack_q & ~ack_qq;
    assign ack_fall  = ~ack_q & ack_qq;

    assign sd_lba    = 32'({slot_r, sec});
    assign fsm_state = state;

    logic auto_go;

`ifdef BRAM_AUTOSAVE_EN
    logic [23:0] idle_cnt;

    // The save fires on the cycle the counter steps from 1 to 0.
    assign auto_go = (state == S_IDLE) && dirty && bk_ena && (idle_cnt == 24'd1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= 24'd0;
        end else if (core_wr) begin
            idle_cnt <= AUTOSAVE_CYC;
        end else if ((state == S_IDLE) && dirty && (idle_cnt != 24'd0)) begin
            idle_cnt <= idle_cnt - 24'd1;
        end
    end
`else
    assign auto_go = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            load_q    <= 1'b0;
            load_qq   <= 1'b0;
            save_q    <= 1'b0;
            save_qq   <= 1'b0;
            fmt_q     <= 1'b0;
            fmt_qq    <= 1'b0;
            ack_q     <= 1'b0;
            ack_qq    <= 1'b0;
            slot_r    <= '0;
            sec       <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            bram_b_sd <= 1'b1;
            fmt_idx   <= '0;
            fmt_we    <= 1'b0;
            busy      <= 1'b0;
            loading   <= 1'b0;
            err       <= 1'b0;
            dirty     <= 1'b0;
        end else begin
            load_q  <= load_req;
            load_qq <= load_q;
            save_q  <= save_req;
            save_qq <= save_q;
            fmt_q   <= format_req;
            fmt_qq  <= fmt_q;
            ack_q   <= sd_ack;
            ack_qq  <= ack_q;
            err     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if ((load_edge || save_edge) && bk_ena) begin
                        slot_r  <= slot;
                        sec     <= '0;
                        sd_rd   <= load_edge;
                        sd_wr   <= ~load_edge;
                        busy    <= 1'b1;
                        loading <= load_edge;
                        if (!load_edge) dirty <= 1'b0;
                        state   <= S_XFER;
                    end else if (fmt_edge) begin
                        bram_b_sd <= 1'b0;
                        fmt_we    <= 1'b1;
                        fmt_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= S_FMT;
                    end else if (auto_go) begin
                        sec     <= '0;
                        sd_wr   <= 1'b1;
                        busy    <= 1'b1;
                        loading <= 1'b0;
                        dirty   <= 1'b0;
                        state   <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                    if (ack_fall) begin
                        if (&sec) begin
                            busy    <= 1'b0;
                            loading <= 1'b0;
                            state   <= S_IDLE;
                        end else if (!bk_ena) begin
                            // Image unmounted mid-run: stop rather than address a missing file.
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            loading <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            sec   <= sec + 1'b1;
                            sd_rd <= loading;
                            sd_wr <= ~loading;
                        end
                    end
                end

                S_FMT: begin
                    if (fmt_idx == FMT_IDX_W'(FMT_WORDS - 1)) begin
                        fmt_we    <= 1'b0;
                        fmt_idx   <= '0;
                        bram_b_sd <= 1'b1;
                        busy      <= 1'b0;
                        dirty     <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        fmt_idx <= fmt_idx + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // A core write always wins over a clear in the same cycle.
            if (core_wr) dirty <= 1'b1;
        end
    end

endmodule
